// File: rtl/demm_axil_cfg_master.sv
// demm_axil_cfg_master: turns a cmd stream (addr/data/rw) into single AXI4-Lite
// transactions towards the DEMM register slave, one outstanding at a time.
// Results come back on a rsp stream. Completed and failed transactions are counted.
`timescale 1ns/1ps
module demm_axil_cfg_master #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int ERR_CNT_W = 16
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  // command stream
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [ADDR_W-1:0]    cmd_addr,
  input  logic [DATA_W-1:0]    cmd_wdata,
  // response stream
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_write,
  output logic [DATA_W-1:0]    rsp_rdata,
  output logic [1:0]           rsp_resp,
  // AXI4-Lite master
  output logic                 m_axil_awvalid,
  input  logic                 m_axil_awready,
  output logic [ADDR_W-1:0]    m_axil_awaddr,
  output logic                 m_axil_wvalid,
  input  logic                 m_axil_wready,
  output logic [DATA_W-1:0]    m_axil_wdata,
  input  logic                 m_axil_bvalid,
  output logic                 m_axil_bready,
  input  logic [1:0]           m_axil_bresp,
  output logic                 m_axil_arvalid,
  input  logic                 m_axil_arready,
  output logic [ADDR_W-1:0]    m_axil_araddr,
  input  logic                 m_axil_rvalid,
  output logic                 m_axil_rready,
  input  logic [DATA_W-1:0]    m_axil_rdata,
  input  logic [1:0]           m_axil_rresp,
  // status
  output logic                 busy,
  output logic [31:0]          txn_cnt,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP} state_t;

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic                  bready_q, bready_d;
  logic                  arvalid_q, arvalid_d;
  logic                  rready_q, rready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_write_q, rsp_write_d;
  logic [DATA_W-1:0]     rsp_rdata_q, rsp_rdata_d;
  logic [1:0]            rsp_resp_q, rsp_resp_d;
  logic [31:0]           txn_cnt_q, txn_cnt_d;
  logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;

  logic aw_hs, w_hs;
  assign aw_hs = awvalid_q && m_axil_awready;
  assign w_hs  = wvalid_q  && m_axil_wready;

  // Next-state, AXI channel valids/readies, response capture and counters
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    txn_cnt_d   = txn_cnt_q;
    err_cnt_d   = err_cnt_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d      = cmd_addr;
          wdata_d     = cmd_wdata;
          rsp_write_d = cmd_write;
          if (cmd_write) begin
            state_d   = WR_REQ;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
          end else begin
            state_d   = RD_REQ;
            arvalid_d = 1'b1;
          end
        end
      end
      // AW and W complete independently, in any order or together
      WR_REQ: begin
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          state_d  = WR_RESP;
          bready_d = 1'b1;
        end
      end
      WR_RESP: begin
        if (m_axil_bvalid) begin
          state_d     = RSP;
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_resp_d  = m_axil_bresp;
          txn_cnt_d   = txn_cnt_q + 32'd1;
          if (m_axil_bresp != 2'b00 && err_cnt_q != '1)
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
      end
      RD_REQ: begin
        if (m_axil_arready) begin
          state_d   = RD_DATA;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end
      RD_DATA: begin
        if (m_axil_rvalid) begin
          state_d     = RSP;
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = m_axil_rdata;
          rsp_resp_d  = m_axil_rresp;
          txn_cnt_d   = txn_cnt_q + 32'd1;
          if (m_axil_rresp != 2'b00 && err_cnt_q != '1)
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
      end
      RSP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers, synchronous active-low reset
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
      txn_cnt_q   <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
      txn_cnt_q   <= txn_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign cmd_ready      = (state_q == IDLE);
  assign busy           = (state_q != IDLE);
  assign m_axil_awvalid = awvalid_q;
  assign m_axil_awaddr  = addr_q;
  assign m_axil_wvalid  = wvalid_q;
  assign m_axil_wdata   = wdata_q;
  assign m_axil_bready  = bready_q;
  assign m_axil_arvalid = arvalid_q;
  assign m_axil_araddr  = addr_q;
  assign m_axil_rready  = rready_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_write      = rsp_write_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign rsp_resp       = rsp_resp_q;
  assign txn_cnt        = txn_cnt_q;
  assign err_cnt        = err_cnt_q;

endmodule

// File: tb/tb_demm_axil_cfg_master.sv
// tb_demm_axil_cfg_master: AXI4-Lite slave model with 8 mapped words (0x00-0x1C),
// 0xDEADBEEF elsewhere, programmable AW/W stall, SLVERR injection and B hold.
// Expected responses go into a queue at issue and are compared on rsp handshake.
`timescale 1ns/1ps
module tb_demm_axil_cfg_master;
  localparam int AW = 32, DW = 32, EW = 2;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid, rsp_ready = 1'b1, rsp_write;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic          awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  logic [AW-1:0] awaddr, araddr;
  logic [DW-1:0] wdata, rdata;
  logic [1:0]    bresp, rresp;
  logic          busy;
  logic [31:0]   txn_cnt;
  logic [EW-1:0] err_cnt;

  always #5 aclk = ~aclk;

  demm_axil_cfg_master #(.ADDR_W(AW), .DATA_W(DW), .ERR_CNT_W(EW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .m_axil_awvalid(awvalid), .m_axil_awready(awready), .m_axil_awaddr(awaddr),
    .m_axil_wvalid(wvalid), .m_axil_wready(wready), .m_axil_wdata(wdata),
    .m_axil_bvalid(bvalid), .m_axil_bready(bready), .m_axil_bresp(bresp),
    .m_axil_arvalid(arvalid), .m_axil_arready(arready), .m_axil_araddr(araddr),
    .m_axil_rvalid(rvalid), .m_axil_rready(rready), .m_axil_rdata(rdata), .m_axil_rresp(rresp),
    .busy(busy), .txn_cnt(txn_cnt), .err_cnt(err_cnt)
  );

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h exp 0x%0h", tag, got, exp);
  endtask

  // ---------------- slave model ----------------
  logic [31:0] regs [8];
  int          aw_dly = 0, w_dly = 0;
  logic        b_hold = 1'b0, err_inj = 1'b0;
  int          aw_wait, w_wait, aw_hi, w_hi, b_cnt;
  logic        aw_got, w_got, aw_now, w_now;
  logic [31:0] aw_addr_s, w_data_s, wa_eff, wd_eff;

  assign awready = awvalid && !aw_got && (aw_wait >= aw_dly);
  assign wready  = wvalid && !w_got && (w_wait >= w_dly);
  assign arready = arvalid && !rvalid;
  assign aw_now  = aw_got || (awvalid && awready);
  assign w_now   = w_got || (wvalid && wready);
  assign wa_eff  = aw_got ? aw_addr_s : awaddr;
  assign wd_eff  = w_got ? w_data_s : wdata;

  always @(posedge aclk) begin
    if (!aresetn) begin
      aw_wait <= 0; w_wait <= 0; aw_hi <= 0; w_hi <= 0; b_cnt <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; aw_addr_s <= '0; w_data_s <= '0;
      bvalid <= 1'b0; bresp <= '0; rvalid <= 1'b0; rresp <= '0; rdata <= '0;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      aw_hi <= aw_hi + int'(awvalid);
      w_hi  <= w_hi + int'(wvalid);
      if (awvalid && !awready) aw_wait <= aw_wait + 1; else aw_wait <= 0;
      if (wvalid && !wready) w_wait <= w_wait + 1; else w_wait <= 0;
      if (awvalid && awready) begin aw_got <= 1'b1; aw_addr_s <= awaddr; end
      if (wvalid && wready) begin w_got <= 1'b1; w_data_s <= wdata; end
      if (aw_now && w_now && !bvalid && !b_hold) begin
        bvalid <= 1'b1;
        bresp  <= err_inj ? 2'b10 : 2'b00;
        aw_got <= 1'b0;
        w_got  <= 1'b0;
        if (wa_eff < 32'h20) regs[wa_eff[4:2]] <= wd_eff;
      end
      if (bvalid && bready) begin bvalid <= 1'b0; b_cnt <= b_cnt + 1; end
      if (arvalid && arready) begin
        rvalid <= 1'b1;
        rresp  <= err_inj ? 2'b10 : 2'b00;
        rdata  <= (araddr < 32'h20) ? regs[araddr[4:2]] : 32'hDEAD_BEEF;
      end
      if (rvalid && rready) rvalid <= 1'b0;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct { logic wr; logic [31:0] rdata; logic [1:0] resp; } exp_t;
  exp_t sb_q[$];

  // Compare each response on the handshake cycle against the oldest expectation
  always @(negedge aclk) begin
    if (aresetn && rsp_valid && rsp_ready) begin
      if (sb_q.size() == 0) chk("sb_unexpected_rsp", rsp_valid, 1'b0);
      else begin
        chk("rsp_write", rsp_write, sb_q[0].wr);
        chk("rsp_rdata", rsp_rdata, sb_q[0].rdata);
        chk("rsp_resp",  rsp_resp,  sb_q[0].resp);
        void'(sb_q.pop_front());
      end
    end
  end

  // Issue one command and return after its response handshake (rsp_ready high)
  task automatic do_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] er, input logic [1:0] eresp, input bit chk_lat);
    int n;
    sb_q.push_back(exp_t'{wr, er, eresp});
    @(posedge aclk); #1;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    n = 0;
    do begin @(negedge aclk); n++; end while (!cmd_ready && n < 50);
    if (!cmd_ready) chk("acc_timeout", cmd_ready, 1'b1);
    @(posedge aclk); #1;
    cmd_valid = 1'b0;
    if (chk_lat && wr) begin
      chk("awvalid_acc+1", awvalid, 1'b1);
      chk("wvalid_acc+1",  wvalid,  1'b1);
    end
    n = 1;
    while (!rsp_valid && n < 100) begin @(posedge aclk); #1; n++; end
    if (chk_lat) chk("rsp_latency", n, 3);
    else if (!rsp_valid) chk("rsp_timeout", rsp_valid, 1'b1);
    n = 0;
    while (!(rsp_valid && rsp_ready) && n < 100) begin @(posedge aclk); #1; n++; end
    @(posedge aclk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, acc_seen, chg, aw0, w0, b0;
    // reset values
    aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_txn", txn_cnt, 0);
    chk("rst_err", err_cnt, 0);
    chk("rst_valids", {awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 6'b0);
    chk("rst_rsp", {rsp_write, rsp_rdata, rsp_resp}, 35'b0);
    chk("rst_addr", {awaddr, araddr, wdata}, 96'b0);
    aresetn = 1'b1;

    // write then readback, zero-wait
    do_cmd(1'b1, 32'h04, 32'h10, 32'h0, 2'b00, 1'b1);
    do_cmd(1'b0, 32'h04, 32'h0, 32'h10, 2'b00, 1'b1);
    chk("txn_after_2", txn_cnt, 2);

    // AW stalled 4 cycles, W immediate
    aw0 = aw_hi; w0 = w_hi; b0 = b_cnt;
    aw_dly = 4;
    do_cmd(1'b1, 32'h08, 32'hA5A5_0001, 32'h0, 2'b00, 1'b0);
    aw_dly = 0;
    chk("awvalid_cycles", aw_hi - aw0, 5);
    chk("wvalid_cycles", w_hi - w0, 1);
    chk("b_consumed", b_cnt - b0, 1);
    do_cmd(1'b0, 32'h08, 32'h0, 32'hA5A5_0001, 2'b00, 1'b0);

    // unmapped read
    do_cmd(1'b0, 32'h20, 32'h0, 32'hDEAD_BEEF, 2'b00, 1'b0);

    // SLVERR reads, err_cnt saturates at 3
    err_inj = 1'b1;
    for (int i = 0; i < 4; i++) begin
      do_cmd(1'b0, 32'h00, 32'h0, 32'h0, 2'b10, 1'b0);
      chk("err_cnt_sat", err_cnt, (i < 3) ? i + 1 : 3);
      chk("txn_during_err", txn_cnt, 6 + i);
    end
    err_inj = 1'b0;

    // rsp backpressure: response stable, second command not accepted
    rsp_ready = 1'b0;
    sb_q.push_back(exp_t'{1'b1, 32'h0, 2'b00});
    @(posedge aclk); #1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0C; cmd_wdata = 32'h77;
    n = 0;
    do begin @(negedge aclk); n++; end while (!cmd_ready && n < 50);
    @(posedge aclk); #1;
    cmd_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 100) begin @(posedge aclk); #1; n++; end
    sb_q.push_back(exp_t'{1'b0, 32'h77, 2'b00});
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0C; cmd_wdata = 32'h0;
    acc_seen = 0; chg = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge aclk);
      if (cmd_ready) acc_seen++;
      if (!rsp_valid || rsp_rdata != 32'h0 || rsp_resp != 2'b00 || !rsp_write) chg++;
    end
    chk("bp_no_accept", acc_seen, 0);
    chk("bp_rsp_stable", chg, 0);
    @(posedge aclk); #1;
    rsp_ready = 1'b1;
    n = 0;
    do begin @(negedge aclk); n++; end while (!cmd_ready && n < 50);
    chk("b2b_accept_cycle", n, 2);
    @(posedge aclk); #1;
    cmd_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 100) begin @(posedge aclk); #1; n++; end
    @(posedge aclk); #1;

    // reset during WR_RESP
    b_hold = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h10; cmd_wdata = 32'h55;
    n = 0;
    do begin @(negedge aclk); n++; end while (!cmd_ready && n < 50);
    @(posedge aclk); #1;
    cmd_valid = 1'b0;
    n = 0;
    while (!bready && n < 100) begin @(posedge aclk); #1; n++; end
    chk("wr_resp_bready", bready, 1'b1);
    chk("wr_resp_busy", busy, 1'b1);
    aresetn = 1'b0;
    @(posedge aclk); #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_cmd_ready", cmd_ready, 1'b1);
    chk("mid_rst_valids", {awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 6'b0);
    chk("mid_rst_rsp", {rsp_write, rsp_rdata, rsp_resp}, 35'b0);
    chk("mid_rst_addr", {awaddr, araddr, wdata}, 96'b0);
    chk("mid_rst_cnt", {txn_cnt, 30'b0, err_cnt}, 64'b0);
    aresetn = 1'b1;
    b_hold = 1'b0;

    // back to normal operation after reset (slave regs were cleared too)
    do_cmd(1'b0, 32'h0C, 32'h0, 32'h0, 2'b00, 1'b1);
    chk("txn_after_rst", txn_cnt, 1);
    chk("sb_drained", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
